// File: rtl/output_periph_pkg.sv
// Shared constants, LCD FSM states and store helpers
// for the output peripheral bank.
package output_periph_pkg;

  localparam logic [3:0] HEX_BASE   = 4'h0;
  localparam logic [3:0] LEDR_IDX   = 4'h8;
  localparam logic [3:0] LEDG_IDX   = 4'h9;
  localparam logic [3:0] LCD_IDX    = 4'hA;
  localparam logic [3:0] STATUS_IDX = 4'hB;

  localparam int LCD_DATA_LSB = 0;
  localparam int LCD_RS_BIT   = 8;
  localparam int LCD_RW_BIT   = 9;
  localparam int LCD_ON_BIT   = 31;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_OVR_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } lcd_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b+:8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/output_periph_bank_lcd_strobe_fsm.sv
// Timed LCD enable strobe: SETUP -> PULSE (lcd_en) -> HOLD.
// ready also covers the last HOLD cycle so transfers chain back to back.
module lcd_strobe_fsm
  import output_periph_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic lcd_en
);

  localparam int MAXC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  lcd_state_e    state;
  logic [CW-1:0] cnt;
  logic          last;

  assign last   = (cnt == '0);
  assign ready  = (state == IDLE) || (state == HOLD && last);
  assign busy   = (state != IDLE);
  assign lcd_en = (state == PULSE);

  // phase sequencing with a per-phase reload of the down counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (start && ready) begin
      state <= SETUP;
      cnt   <= CW'(SETUP_CYC - 1);
    end else begin
      unique case (state)
        IDLE: cnt <= '0;
        SETUP:
          if (last) begin
            state <= PULSE;
            cnt   <= CW'(PULSE_CYC - 1);
          end else cnt <= cnt - CW'(1);
        PULSE:
          if (last) begin
            state <= HOLD;
            cnt   <= CW'(HOLD_CYC - 1);
          end else cnt <= cnt - CW'(1);
        HOLD:
          if (last) state <= IDLE;
          else cnt <= cnt - CW'(1);
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/output_periph_bank.sv
// Memory-mapped HEX/LED/LCD output bank with sticky status.
// Readback path enabled by OUTPUT_PERIPH_READBACK_EN.
module output_periph_bank
  import output_periph_pkg::*;
#(
  parameter int N_HEX     = 8,
  parameter int LEDR_W    = 17,
  parameter int LEDG_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int HOLD_CYC  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               st_en,
  input  logic [3:0]         st_strb,
  input  logic [7:0]         addr,
  input  logic [31:0]        st_data,
  input  logic               ld_en,
  output logic [31:0]        ld_data,
  output logic               ld_valid,
  output logic [N_HEX*7-1:0] hex,
  output logic [LEDR_W-1:0]  ledr,
  output logic [LEDG_W-1:0]  ledg,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_on,
  output logic               lcd_en,
  output logic               lcd_busy
);

  logic [3:0]  idx;
  logic [31:0] mask;
  logic        is_hex;
  logic        lcd_wr;
  logic        lcd_ready;
  logic        ovr_set;
  logic        ovr_clr;
  logic        overrun;

  assign idx     = addr[7:4];
  assign mask    = strb_mask(st_strb);
  assign is_hex  = ({1'b0, idx} < 5'(N_HEX));
  assign lcd_wr  = st_en && (idx == LCD_IDX);
  assign ovr_set = lcd_wr && !lcd_ready;
  assign ovr_clr = st_en && (idx == STATUS_IDX) && st_strb[0]
                   && st_data[ST_OVR_BIT];

  lcd_strobe_fsm #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .HOLD_CYC (HOLD_CYC)
  ) u_fsm (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (lcd_wr),
    .ready (lcd_ready),
    .busy  (lcd_busy),
    .lcd_en(lcd_en)
  );

  // byte-strobed register writes; LCD only updates when a transfer starts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hex      <= '0;
      ledr     <= '0;
      ledg     <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_on   <= 1'b0;
    end else if (st_en) begin
      if (is_hex && st_strb[0]) begin
        for (int k = 0; k < N_HEX; k++)
          if (idx == 4'(k)) hex[7*k+:7] <= st_data[6:0];
      end
      if (idx == LEDR_IDX)
        ledr <= (ledr & ~mask[LEDR_W-1:0])
              | (st_data[LEDR_W-1:0] & mask[LEDR_W-1:0]);
      if (idx == LEDG_IDX)
        ledg <= (ledg & ~mask[LEDG_W-1:0])
              | (st_data[LEDG_W-1:0] & mask[LEDG_W-1:0]);
      if (lcd_wr && lcd_ready) begin
        lcd_data <= (lcd_data & ~mask[LCD_DATA_LSB+:8])
                  | (st_data[LCD_DATA_LSB+:8] & mask[LCD_DATA_LSB+:8]);
        if (mask[LCD_RS_BIT]) lcd_rs <= st_data[LCD_RS_BIT];
        if (mask[LCD_RW_BIT]) lcd_rw <= st_data[LCD_RW_BIT];
        if (mask[LCD_ON_BIT]) lcd_on <= st_data[LCD_ON_BIT];
      end
    end
  end

  // sticky overrun; a new overrun beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

`ifdef OUTPUT_PERIPH_READBACK_EN
  logic [31:0] rd;
  logic        unused_ok;

  assign unused_ok = ^{addr[3:0], st_data, mask};

  // readback mux over the current (pre-store) register state
  always_comb begin
    rd = '0;
    unique case (idx)
      LEDR_IDX:   rd = 32'(ledr);
      LEDG_IDX:   rd = 32'(ledg);
      LCD_IDX: begin
        rd[LCD_DATA_LSB+:8] = lcd_data;
        rd[LCD_RS_BIT]      = lcd_rs;
        rd[LCD_RW_BIT]      = lcd_rw;
        rd[LCD_ON_BIT]      = lcd_on;
      end
      STATUS_IDX: begin
        rd[ST_BUSY_BIT] = lcd_busy;
        rd[ST_OVR_BIT]  = overrun;
      end
      default: ;
    endcase
    for (int k = 0; k < N_HEX; k++)
      if (idx == HEX_BASE + 4'(k)) rd = 32'(hex[7*k+:7]);
  end

  // one-cycle load response; data holds until the next load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_data  <= '0;
      ld_valid <= 1'b0;
    end else begin
      ld_valid <= ld_en;
      if (ld_en) ld_data <= rd;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{addr[3:0], st_data, mask, ld_en, overrun};
  assign ld_data   = '0;
  assign ld_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_output_periph_bank.sv
// Self-checking bench for output_periph_bank (N_HEX=4).
// Load expectations follow OUTPUT_PERIPH_READBACK_EN.
module tb_output_periph_bank;

  localparam int NH = 4;
`ifdef OUTPUT_PERIPH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          st_en = 1'b0;
  logic [3:0]    st_strb = '0;
  logic [7:0]    addr = '0;
  logic [31:0]   st_data = '0;
  logic          ld_en = 1'b0;
  logic [31:0]   ld_data;
  logic          ld_valid;
  logic [NH*7-1:0] hex;
  logic [16:0]   ledr;
  logic [7:0]    ledg;
  logic [7:0]    lcd_data;
  logic          lcd_rs;
  logic          lcd_rw;
  logic          lcd_on;
  logic          lcd_en;
  logic          lcd_busy;

  int total = 0;
  int bad = 0;
  logic [31:0] ldq[$];
  logic [1:0]  wq[$];

  output_periph_bank #(.N_HEX(NH)) dut (
    .clk_i(clk), .rst_i(rst), .st_en(st_en), .st_strb(st_strb),
    .addr(addr), .st_data(st_data), .ld_en(ld_en),
    .ld_data(ld_data), .ld_valid(ld_valid), .hex(hex),
    .ledr(ledr), .ledg(ledg), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on),
    .lcd_en(lcd_en), .lcd_busy(lcd_busy)
  );

  always #5 clk = ~clk;

  task automatic bus(input logic s, input logic l, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    st_en = s; ld_en = l; addr = a; st_data = d; st_strb = b;
    @(posedge clk); #1;
    st_en = 1'b0; ld_en = 1'b0; st_strb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
    total++;
    if ({hex, ledr, ledg, lcd_data, lcd_rs, lcd_rw, lcd_on, lcd_en,
         lcd_busy, ld_valid, ld_data} !== '0) begin
      bad++; $display("FAIL reset_outs got hex=%h ledr=%h lcd=%h want 0",
                      hex, ledr, lcd_data);
    end
    ldq.push_back(32'h0);
    bus(1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL reset_ld got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    idle(1); total++;
    if (ld_valid !== 1'b0) begin
      bad++; $display("FAIL ld_valid_pulse got=%b want=0", ld_valid);
    end
  endtask

  task automatic test_leds;
    logic [31:0] e;
    bus(1'b1, 1'b0, 8'h80, 32'hA5A5A5A5, 4'b0101);
    total++;
    if (ledr !== 17'h100A5) begin
      bad++; $display("FAIL ledr_strb got=%h want=%h", ledr, 17'h100A5);
    end
    bus(1'b1, 1'b0, 8'h90, 32'h12345678, 4'b1111);
    total++;
    if (ledg !== 8'h78 || ledr !== 17'h100A5) begin
      bad++; $display("FAIL ledg_wr got=%h/%h want=78/100a5", ledg, ledr);
    end
    bus(1'b1, 1'b0, 8'h80, 32'h00005A00, 4'b0010);
    total++;
    if (ledr !== 17'h15AA5) begin
      bad++; $display("FAIL ledr_byte1 got=%h want=%h", ledr, 17'h15AA5);
    end
    ldq.push_back(RB ? 32'h00015AA5 : 32'h0);
    bus(1'b0, 1'b1, 8'h80, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_ledr got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    ldq.push_back(RB ? 32'h00000078 : 32'h0);
    bus(1'b0, 1'b1, 8'h90, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_ledg got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
  endtask

  task automatic test_lcd;
    logic [1:0] w;
    bus(1'b1, 1'b0, 8'hA0, 32'h80000141, 4'hF);
    for (int i = 0; i < 20; i++) wq.push_back({i >= 2 && i < 14, i < 16});
    for (int i = 0; i < 20; i++) begin
      w = wq.pop_front(); total++;
      if ({lcd_en, lcd_busy} !== w) begin
        bad++; $display("FAIL lcd_wave c%0d got=%b want=%b", i, {lcd_en, lcd_busy}, w);
      end
      total++;
      if ({lcd_data, lcd_rs, lcd_rw, lcd_on} !== {8'h41, 1'b1, 1'b0, 1'b1}) begin
        bad++; $display("FAIL lcd_bus c%0d got=%h want=%h", i,
                        {lcd_data, lcd_rs, lcd_rw, lcd_on}, {8'h41, 3'b101});
      end
      idle(1);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] e;
    bus(1'b1, 1'b0, 8'hA0, 32'h00000233, 4'hF);
    idle(4);
    bus(1'b1, 1'b0, 8'hA0, 32'h80000155, 4'hF);
    total++;
    if ({lcd_data, lcd_rs, lcd_rw, lcd_on} !== {8'h33, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovr_drop got=%h want=%h",
                      {lcd_data, lcd_rs, lcd_rw, lcd_on}, {8'h33, 3'b010});
    end
    ldq.push_back(RB ? 32'h3 : 32'h0);
    bus(1'b0, 1'b1, 8'hB0, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL status_ovr got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    bus(1'b1, 1'b0, 8'hB0, 32'h2, 4'b0010);
    ldq.push_back(RB ? 32'h3 : 32'h0);
    bus(1'b0, 1'b1, 8'hB0, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL status_noclr got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    bus(1'b1, 1'b0, 8'hB0, 32'h2, 4'b0001);
    ldq.push_back(RB ? 32'h1 : 32'h0);
    bus(1'b0, 1'b1, 8'hB0, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL status_clr got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    for (int n = 0; n < 40 && lcd_busy; n++) idle(1);
    total++;
    if (lcd_busy !== 1'b0) begin
      bad++; $display("FAIL busy_timeout got=%b want=0", lcd_busy);
    end
    ldq.push_back(32'h0);
    bus(1'b0, 1'b1, 8'hB0, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL status_idle got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] w;
    bus(1'b1, 1'b0, 8'hA0, 32'h80000141, 4'hF);
    for (int i = 0; i < 16; i++) wq.push_back({i >= 2 && i < 14, 1'b1});
    for (int i = 0; i < 16; i++) begin
      w = wq.pop_front(); total++;
      if ({lcd_en, lcd_busy, lcd_data} !== {w, 8'h41}) begin
        bad++; $display("FAIL b2b_first c%0d got=%b/%h want=%b/41", i,
                        {lcd_en, lcd_busy}, lcd_data, w);
      end
      if (i < 15) idle(1);
    end
    bus(1'b1, 1'b0, 8'hA0, 32'h80000142, 4'hF);
    for (int i = 0; i < 20; i++) wq.push_back({i >= 2 && i < 14, i < 16});
    for (int i = 0; i < 20; i++) begin
      w = wq.pop_front(); total++;
      if ({lcd_en, lcd_busy, lcd_data} !== {w, 8'h42}) begin
        bad++; $display("FAIL b2b_second c%0d got=%b/%h want=%b/42", i,
                        {lcd_en, lcd_busy}, lcd_data, w);
      end
      idle(1);
    end
  endtask

  task automatic test_hex_load;
    logic [31:0] e;
    bus(1'b1, 1'b0, 8'h00, 32'h0000003F, 4'h1);
    total++;
    if (hex[6:0] !== 7'h3F) begin
      bad++; $display("FAIL hex0_wr got=%h want=3f", hex[6:0]);
    end
    ldq.push_back(RB ? 32'h3F : 32'h0);
    bus(1'b1, 1'b1, 8'h00, 32'h00000086, 4'h1);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_prestore got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    total++;
    if (hex[6:0] !== 7'h06) begin
      bad++; $display("FAIL hex0_new got=%h want=06", hex[6:0]);
    end
    ldq.push_back(RB ? 32'h06 : 32'h0);
    bus(1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_poststore got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    bus(1'b1, 1'b0, 8'h30, 32'hFFFFFFFF, 4'b1110);
    total++;
    if (hex !== {7'h00, 7'h00, 7'h00, 7'h06}) begin
      bad++; $display("FAIL hex3_nostrb got=%h want=%h", hex, {21'h0, 7'h06});
    end
    bus(1'b1, 1'b0, 8'h3C, 32'hFFFFFFFF, 4'b0001);
    total++;
    if (hex !== {7'h7F, 7'h00, 7'h00, 7'h06}) begin
      bad++; $display("FAIL hex3_wr got=%h want=%h", hex, {7'h7F, 14'h0, 7'h06});
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] e;
    bus(1'b1, 1'b0, 8'hC0, 32'hFFFFFFFF, 4'hF);
    bus(1'b1, 1'b0, 8'h50, 32'hFFFFFFFF, 4'hF);
    bus(1'b1, 1'b0, 8'h70, 32'hFFFFFFFF, 4'hF);
    total++;
    if ({hex, ledr, ledg, lcd_data, lcd_rs, lcd_rw, lcd_on, lcd_busy} !==
        {7'h7F, 14'h0, 7'h06, 17'h15AA5, 8'h78, 8'h42, 3'b101, 1'b0}) begin
      bad++; $display("FAIL unmapped_st got=%h/%h/%h/%h want=%h/15aa5/78/42",
                      hex, ledr, ledg, lcd_data, {7'h7F, 14'h0, 7'h06});
    end
    ldq.push_back(32'h0);
    bus(1'b0, 1'b1, 8'h50, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_hex5 got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    ldq.push_back(32'h0);
    bus(1'b0, 1'b1, 8'hC0, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_c0 got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
    ldq.push_back(RB ? 32'h80000142 : 32'h0);
    bus(1'b0, 1'b1, 8'hA7, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL ld_lcd got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    bus(1'b1, 1'b0, 8'hA0, 32'h80000141, 4'hF);
    idle(4);
    total++;
    if (lcd_en !== 1'b1) begin
      bad++; $display("FAIL mid_pulse got=%b want=1", lcd_en);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({lcd_en, lcd_busy} !== 2'b00) begin
      bad++; $display("FAIL async_rst got=%b want=00", {lcd_en, lcd_busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    total++;
    if ({hex, ledr, ledg, lcd_data, lcd_rs, lcd_rw, lcd_on, lcd_en,
         lcd_busy, ld_valid, ld_data} !== '0) begin
      bad++; $display("FAIL rst_outs got hex=%h ledr=%h lcd=%h want 0",
                      hex, ledr, lcd_data);
    end
    ldq.push_back(32'h0);
    bus(1'b0, 1'b1, 8'h00, 32'h0, 4'h0);
    e = ldq.pop_front(); total++;
    if (ld_valid !== RB || ld_data !== e) begin
      bad++; $display("FAIL rst_ld_hex got=%b/%h want=%b/%h", ld_valid, ld_data, RB, e);
    end
  endtask

  initial begin
    test_reset;
    test_leds;
    test_lcd;
    test_overrun;
    test_back_to_back;
    test_hex_load;
    test_unmapped;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
